// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and constants for RSA engine access
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    BUSY  = 3'd3,
    DONE  = 3'd4,
    ABORT = 3'd5
  } arb_state_t;

  localparam int REQ_GPIO = 0;
  localparam int REQ_SPI  = 1;

  localparam int RSA_TIMEOUT_CYCLES = 40000;

endpackage

// File: rtl/rsa_req_arbiter_rr_pick.sv
// rtl/rsa_req_arbiter_rr_pick.sv - combinational round-robin selector (rr_pick)
module rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  assign valid = |req;

  // Walk from the farthest candidate back to rr_ptr+1 so the nearest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[IDX_W'((int'(rr_ptr) + i) % NUM_REQ)]) begin
        idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/rsa_req_arbiter.sv
// rtl/rsa_req_arbiter.sv - round-robin owner arbitration for the shared RSA engine
// Watchdog abort is built only when RSA_ARB_TIMEOUT_EN is defined.
module rsa_req_arbiter
  import rsa_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = RSA_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] abort,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] aborted,
  output logic               busy,
  output logic               rsa_start,
  output logic               rsa_stop,
  input  logic               rsa_eoc,
  output logic               timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 ||
      ((TIMEOUT_CYCLES - 1) >> TIMEOUT_W) != 0) begin : g_bad_cfg
    $error("rsa_req_arbiter: unsupported NUM_REQ/TIMEOUT configuration");
  end

  arb_state_t         state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] aborted_q;
  logic               busy_q;
  logic               start_q;
  logic               stop_q;
  logic               timeout_q;
  logic               wd_expire;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

`ifdef RSA_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] wd_cnt;

  assign wd_expire = (wd_cnt == WD_LAST);

  // Saturating count of BUSY cycles since the start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (ena) begin
      if (state == START) begin
        wd_cnt <= '0;
      end else if (state == BUSY && wd_cnt != '1) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      owner     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      aborted_q <= '0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (ena) begin
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      done_q    <= '0;
      aborted_q <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_idx;
            gnt_q     <= NUM_REQ'(1) << pick_idx;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          start_q <= 1'b1;
          state   <= START;
        end
        START: begin
          state <= BUSY;
        end
        BUSY: begin
          // Completion outranks a simultaneous abort or watchdog expiry.
          if (rsa_eoc) begin
            done_q <= gnt_q;
            state  <= DONE;
          end else if (abort[owner] || wd_expire) begin
            aborted_q <= gnt_q;
            stop_q    <= 1'b1;
            timeout_q <= !abort[owner];
            state     <= ABORT;
          end
        end
        DONE, ABORT: begin
          rr_ptr <= owner;
          gnt_q  <= '0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          gnt_q  <= '0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Pulses are held in their registers across a stall and only shown while ena=1.
  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
  assign rsa_start = start_q & ena;
  assign rsa_stop  = stop_q & ena;
  assign done      = done_q & {NUM_REQ{ena}};
  assign aborted   = aborted_q & {NUM_REQ{ena}};

endmodule

// File: doc/rsa_req_arbiter.md
Name: rsa_req_arbiter

Overview:
- Shares the single RSA encryption engine and its enable/reset sequencer between NUM_REQ requesters (index 0 = GPIO, index 1 = SPI).
- Performs round-robin arbitration and issues one start pulse per granted job.
- Waits for end-of-conversion, then returns a done pulse to the owning requester.
- Supports owner abort and, optionally, a watchdog timeout; both cancel the job with a stop pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_W, 16, width of the watchdog counter.
- TIMEOUT_CYCLES, 40000, BUSY cycles before a forced abort (must fit in TIMEOUT_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ena  in  1  design enable; when 0, all state and counters freeze.
- req  in  NUM_REQ  level job requests, one bit per requester.
- abort  in  NUM_REQ  level cancel; only the current owner's bit is honoured.
- gnt  out  NUM_REQ  one-hot owner; drives the operand/key mux select.
- done  out  NUM_REQ  one-cycle pulse to the owner on successful completion.
- aborted  out  NUM_REQ  one-cycle pulse to the owner on cancel or timeout.
- busy  out  1  high in every state except IDLE.
- rsa_start  out  1  one-cycle start pulse to the engine sequencer.
- rsa_stop  out  1  one-cycle stop pulse to the engine sequencer.
- rsa_eoc  in  1  end-of-conversion from the engine sequencer.
- timeout  out  1  sticky flag; set on watchdog expiry, cleared by rst or the next grant.

Behaviour:
- Reset values (rst=1 at a clk edge):
  - state=IDLE, rr_ptr=NUM_REQ-1, owner=0, wd_cnt=0.
  - gnt, done, aborted, busy, rsa_start, rsa_stop, timeout all 0.
- ena gating:
  - When ena=0: state, owner, rr_ptr and wd_cnt hold.
  - rsa_start, rsa_stop, done and aborted are forced 0, so each pulse is asserted exactly once, on a cycle with ena=1.
  - gnt and busy follow the held state.
- State machine (advances only when ena=1):
  - IDLE: if any req bit is set, select the first set index searching from rr_ptr+1 upward with wrap modulo NUM_REQ. Latch owner, clear timeout, go to GRANT. Otherwise stay in IDLE.
  - GRANT: gnt[owner]=1 (gnt is held through BUSY and DONE/ABORT). One setup cycle for the operand mux, then go to START.
  - START: rsa_start=1 for one cycle; clear wd_cnt; go to BUSY.
  - BUSY, evaluated in priority order:
    - rsa_eoc=1 -> DONE.
    - else abort[owner]=1 -> ABORT.
    - else watchdog expiry -> ABORT.
    - else wd_cnt++ and stay in BUSY.
  - DONE: done[owner]=1; rr_ptr<=owner; go to IDLE.
  - ABORT: rsa_stop=1 and aborted[owner]=1; rr_ptr<=owner; go to IDLE.
  - Unreachable state encodings -> IDLE, all outputs 0.
- Latency:
  - req rise in IDLE -> rsa_start asserted 2 cycles later.
  - rsa_eoc -> done asserted the next cycle.
  - Minimum job turnaround is 5 cycles.
- Boundary conditions:
  - req deassertion during GRANT/START/BUSY is ignored; only abort cancels a job.
  - abort bits from non-owners are ignored.
  - rsa_eoc in the same cycle as abort or expiry: completion wins.
  - rsa_eoc outside BUSY is ignored.
  - A requester still holding req after done is re-arbitrated; round-robin guarantees any other pending requester is served first.
  - rst mid-job returns to IDLE with no done/aborted/stop pulse. The engine sequencer is reset by the same rst.
  - The watchdog counter saturates and never wraps.

Optional Feature:
- Macro RSA_ARB_TIMEOUT_EN.
- Defined:
  - wd_cnt and TIMEOUT_CYCLES are implemented.
  - Expiry when wd_cnt == TIMEOUT_CYCLES-1 in BUSY: sets timeout and forces ABORT.
- Undefined:
  - No counter is synthesised and timeout is tied to 0.
  - BUSY exits only on rsa_eoc or abort.

Decomposition:
- Shared package rsa_pkg holds:
  - arbiter state enum arb_state_t (IDLE, GRANT, START, BUSY, DONE, ABORT);
  - requester index constants REQ_GPIO=0 and REQ_SPI=1;
  - default TIMEOUT_CYCLES.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req, rr_ptr.
  - Outputs: valid, idx.
  - Reused by any future multi-source access.

Test Plan:
1. Reset and single job: rst 2 cycles; req=01. Check gnt=01 at cycle 1 and rsa_start pulse at cycle 2. Drive rsa_eoc at cycle 10 -> done=01 at cycle 11, busy low at cycle 12.
2. Fairness: req=11 held for 4 jobs, each acknowledged by rsa_eoc 3 cycles after start. Grant order must be 0,1,0,1, with exactly 4 start pulses.
3. Abort versus eoc: owner 1 asserts abort 5 cycles into BUSY -> rsa_stop and aborted=10 the next cycle. Repeat with abort and rsa_eoc in the same cycle -> done=10 with no rsa_stop.
4. Watchdog (RSA_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): no rsa_eoc. Check rsa_stop and aborted 9 cycles after the start pulse, timeout=1, and timeout cleared on the next grant.
5. ena stall: drop ena for 3 cycles while in START. rsa_start must be asserted exactly once, after ena returns. gnt must stay stable throughout.
6. Reset mid-BUSY: assert rst. Next cycle all outputs are 0 and there is no done, aborted or rsa_stop pulse. A fresh req=10 is granted to index 0 first only if req[0] is also set (rr_ptr=NUM_REQ-1).
